pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload plus a control payload using a valid/ready handshake.
- Has a 1-entry skid buffer, so up_ready is a pure register output with no combinational back-path.
- Synchronous flush turns both entries into bubbles. A saturating counter measures backpressure cycles per stage.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/sat_counter.sv | 32 +++
 rtl/pipe_stage_skid.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for valid/ready pipeline stages: stage occupancy states,
// standard control-payload widths and their bubble encodings.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    localparam int unsigned IDEX_CTRL_W  = 16;
    localparam int unsigned EXMEM_CTRL_W = 8;

    localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_NOP  = 16'h0000;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_NOP = 8'h00;

    // Number of beats held by a stage in the given state.
    function automatic logic [1:0] state_occ(input stage_state_e st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             nRst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Counter register: clear, else saturating increment, else hold.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// one-entry skid buffer, synchronous flush and a backpressure cycle counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned         DATA_W   = 128,
    parameter int unsigned         CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]   CTRL_NOP = {CTRL_W{1'b0}},
    parameter int unsigned         SKID     = 1,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              nRst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic              flush,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_count,
    input  logic              bp_clear
);

    localparam bit HAS_SKID = (SKID != 0);

    stage_state_e      state_r;
    stage_state_e      state_nxt_s;
    logic [DATA_W-1:0] main_data_r;
    logic [DATA_W-1:0] main_data_nxt_s;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [CTRL_W-1:0] main_ctrl_nxt_s;
    logic [DATA_W-1:0] skid_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic              skid_load_s;
    logic              skid_clear_s;
    logic              up_ready_r;
    logic              up_ready_s;
    logic              dn_valid_s;
    logic              up_fire_s;
    logic              dn_fire_s;

    assign dn_valid_s = (state_r != ST_EMPTY);
    // Without a skid entry the stage may only accept when its output drains.
    assign up_ready_s = HAS_SKID ? up_ready_r : (!dn_valid_s || dn_ready);
    assign up_fire_s  = up_valid && up_ready_s;
    assign dn_fire_s  = dn_valid_s && dn_ready;

    // Next-state and payload steering; main ctrl drops to NOP whenever the stage empties.
    always_comb begin
        state_nxt_s     = state_r;
        main_data_nxt_s = main_data_r;
        main_ctrl_nxt_s = main_ctrl_r;
        skid_load_s     = 1'b0;
        skid_clear_s    = 1'b0;
        if (flush) begin
            state_nxt_s     = ST_EMPTY;
            main_ctrl_nxt_s = CTRL_NOP;
            skid_clear_s    = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (up_fire_s) begin
                        state_nxt_s     = ST_ONE;
                        main_data_nxt_s = up_data;
                        main_ctrl_nxt_s = up_ctrl;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (up_fire_s && dn_fire_s) begin
                        main_data_nxt_s = up_data;
                        main_ctrl_nxt_s = up_ctrl;
                    end else if (up_fire_s && HAS_SKID) begin
                        state_nxt_s = ST_FULL;
                        skid_load_s = 1'b1;
                    end else if (dn_fire_s) begin
                        state_nxt_s     = ST_EMPTY;
                        main_ctrl_nxt_s = CTRL_NOP;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (dn_fire_s) begin
                        state_nxt_s     = ST_ONE;
                        main_data_nxt_s = skid_data_r;
                        main_ctrl_nxt_s = skid_ctrl_r;
                        skid_clear_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s     = ST_EMPTY;
                    main_ctrl_nxt_s = CTRL_NOP;
                    skid_clear_s    = 1'b1;
                end
            endcase
        end
    end

    // Stage state, main entry and registered up_ready.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_r     <= ST_EMPTY;
            main_data_r <= {DATA_W{1'b0}};
            main_ctrl_r <= CTRL_NOP;
            up_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            main_data_r <= main_data_nxt_s;
            main_ctrl_r <= main_ctrl_nxt_s;
            up_ready_r  <= (state_nxt_s != ST_FULL);
        end
    end

    // Skid entry; never loaded when SKID=0, so it folds away to constants.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            skid_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= CTRL_NOP;
        end else if (skid_load_s) begin
            skid_data_r <= up_data;
            skid_ctrl_r <= up_ctrl;
        end else if (skid_clear_s) begin
            skid_data_r <= skid_data_r;
            skid_ctrl_r <= CTRL_NOP;
        end else begin
            skid_data_r <= skid_data_r;
            skid_ctrl_r <= skid_ctrl_r;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bp_cnt (
        .Clk   (Clk),
        .nRst  (nRst),
        .inc   (dn_valid_s && !dn_ready),
        .clr   (bp_clear),
        .count (bp_count)
    );

    assign up_ready  = up_ready_s;
    assign dn_valid  = dn_valid_s;
    assign dn_data   = main_data_r;
    assign dn_ctrl   = main_ctrl_r;
    assign occupancy = state_occ(state_r);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized and directed bench for pipe_stage_skid: a SKID=1 and a SKID=0
// instance share upstream stimulus and are compared against queue models.
module tb_pipe_stage_skid;

    localparam int unsigned   DW    = 32;
    localparam int unsigned   CW    = 8;
    localparam logic [CW-1:0] NOP   = 8'hA5;
    localparam int unsigned   CNTW  = 4;
    localparam int unsigned   BPMAX = 15;

    logic          Clk;
    logic          nRst;
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic [CW-1:0] up_ctrl;
    logic          flush;
    logic          bp_clear;
    logic          dn_ready;
    logic          dn_ready_b;

    logic            a_up_ready, a_dn_valid, b_up_ready, b_dn_valid;
    logic [DW-1:0]   a_dn_data, b_dn_data;
    logic [CW-1:0]   a_dn_ctrl, b_dn_ctrl;
    logic [1:0]      a_occ, b_occ;
    logic [CNTW-1:0] a_bp, b_bp;

    int n_checks;
    int n_fail;

    logic [CW+DW-1:0] qa[$];
    logic [CW+DW-1:0] qb[$];
    int unsigned      bpa;
    int unsigned      bpb;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1), .CNT_W(CNTW)) u_dut_a (
        .Clk(Clk), .nRst(nRst), .up_valid(up_valid), .up_ready(a_up_ready),
        .up_data(up_data), .up_ctrl(up_ctrl), .flush(flush), .dn_valid(a_dn_valid),
        .dn_ready(dn_ready), .dn_data(a_dn_data), .dn_ctrl(a_dn_ctrl),
        .occupancy(a_occ), .bp_count(a_bp), .bp_clear(bp_clear)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(0), .CNT_W(CNTW)) u_dut_b (
        .Clk(Clk), .nRst(nRst), .up_valid(up_valid), .up_ready(b_up_ready),
        .up_data(up_data), .up_ctrl(up_ctrl), .flush(flush), .dn_valid(b_dn_valid),
        .dn_ready(dn_ready_b), .dn_data(b_dn_data), .dn_ctrl(b_dn_ctrl),
        .occupancy(b_occ), .bp_count(b_bp), .bp_clear(bp_clear)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("a_dn_valid", a_dn_valid, qa.size() > 0);
        chk("a_dn_ctrl", a_dn_ctrl, (qa.size() > 0) ? qa[0][CW+DW-1:DW] : NOP);
        if (qa.size() > 0) chk("a_dn_data", a_dn_data, qa[0][DW-1:0]);
        chk("a_occ", a_occ, qa.size());
        chk("a_up_ready", a_up_ready, qa.size() < 2);
        chk("a_bp", a_bp, bpa);
        chk("b_dn_valid", b_dn_valid, qb.size() > 0);
        chk("b_dn_ctrl", b_dn_ctrl, (qb.size() > 0) ? qb[0][CW+DW-1:DW] : NOP);
        if (qb.size() > 0) chk("b_dn_data", b_dn_data, qb[0][DW-1:0]);
        chk("b_occ", b_occ, qb.size());
        chk("b_bp", b_bp, bpb);
    endtask

    task automatic model_update();
        bit ura, urb, dfa, dfb;
        ura = qa.size() < 2;
        urb = (qb.size() == 0) || dn_ready_b;
        dfa = (qa.size() > 0) && dn_ready;
        dfb = (qb.size() > 0) && dn_ready_b;
        if (bp_clear) bpa = 0;
        else if (qa.size() > 0 && !dn_ready && bpa < BPMAX) bpa++;
        if (bp_clear) bpb = 0;
        else if (qb.size() > 0 && !dn_ready_b && bpb < BPMAX) bpb++;
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (dfa) void'(qa.pop_front());
            if (up_valid && ura) qa.push_back({up_ctrl, up_data});
            if (dfb) void'(qb.pop_front());
            if (up_valid && urb) qb.push_back({up_ctrl, up_data});
        end
    endtask

    task automatic step(input logic uv, input logic [DW-1:0] d, input logic dr,
                        input logic fl, input logic bc);
        up_valid   = uv;
        up_data    = d;
        up_ctrl    = CW'($urandom);
        dn_ready   = dr;
        dn_ready_b = 1'($urandom_range(0, 1));
        flush      = fl;
        bp_clear   = bc;
        #1;
        chk("b_up_ready_comb", b_up_ready, (qb.size() == 0) || dn_ready_b);
        @(posedge Clk);
        model_update();
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic do_reset();
        up_valid = 1'b0;
        flush    = 1'b0;
        bp_clear = 1'b0;
        #2;
        nRst = 1'b0;
        #1;
        chk("rst_a_dn_valid", a_dn_valid, 1'b0);
        chk("rst_a_dn_ctrl", a_dn_ctrl, NOP);
        chk("rst_a_dn_data", a_dn_data, 32'h0);
        chk("rst_a_up_ready", a_up_ready, 1'b1);
        chk("rst_a_occ", a_occ, 2'd0);
        chk("rst_a_bp", a_bp, 4'd0);
        chk("rst_b_dn_valid", b_dn_valid, 1'b0);
        chk("rst_b_occ", b_occ, 2'd0);
        qa.delete();
        qb.delete();
        bpa = 0;
        bpb = 0;
        @(negedge Clk);
        nRst = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        bpa        = 0;
        bpb        = 0;
        nRst       = 1'b1;
        up_valid   = 1'b0;
        up_data    = '0;
        up_ctrl    = '0;
        flush      = 1'b0;
        bp_clear   = 1'b0;
        dn_ready   = 1'b0;
        dn_ready_b = 1'b0;
        do_reset();

        // in-order streaming with no stall
        step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
        chk("stream_first", a_dn_data, 32'h11);
        step(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
        chk("stream_last", a_dn_data, 32'h33);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // fill the skid entry, then drain
        step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
        chk("full_occ", a_occ, 2'd2);
        chk("full_up_ready", a_up_ready, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_second", a_dn_data, 32'hA2);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // flush while full with a concurrent upstream beat
        step(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB0, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", a_dn_valid, 1'b0);
        chk("flush_ctrl", a_dn_ctrl, NOP);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // saturation of the backpressure counter, then clear under stall
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("bp_saturated", a_bp, 4'd15);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("bp_cleared", a_bp, 4'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0));
        end

        // asynchronous reset while full
        step(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hD2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hD3, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 32'hE1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_data", a_dn_data, 32'hE1);
        for (int i = 0; i < 50; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
